bsg_cache_nb_dma_engine: RTL and testbench
==========================================

// Module: bsg_cache_nb_dma_engine
// PURPOSE
//  Responder for the miss handler's DMA command interface. Accepts e_dma_send_refill_addr and
//  e_dma_send_evict_addr from the MHU, issues the memory-side request packet, streams evicted
//  words out of the data mem, and writes refill words into it. Each completed phase is reported
//  to the MHU by a one-cycle dma_done_o pulse. Sits between the MHU/data mem and the memory link.
// PARAMETERS
//  addr_width_p           (none) byte address width
//  word_width_p           (none) data word width; word_width_p/8 bytes per word
//  block_size_in_words_p  (none) words per cache block, >=2
//  sets_p                 (none) sets; index = dma_addr_i[block_offset+:lg_sets]
//  ways_p                 (none) ways; lg_ways = BSG_SAFE_CLOG2(ways_p)
//  dmem_addr_width_lp     (derived) lg_sets+lg_ways+lg_block_size_in_words; {index,way,word}
// PORTS
//  clk_i                          in  1    clock
//  reset_n_i                      in  1    asynchronous active-low reset
//  dma_cmd_i                      in  3    bsg_cache_nb_dma_cmd_e, held by MHU until done
//  dma_addr_i                     in  AW   block-aligned address for the current command
//  dma_way_i                      in  LW   chosen way for evict read / refill write
//  write_fill_data_in_progress_i  in  1    MHU is in WRITE_FILL_DATA; gates refill acceptance
//  dma_done_o                     out 1    one-cycle completion pulse to MHU
//  dma_pkt_v_o / dma_pkt_yumi_i   out/in 1 request packet valid / consumed
//  dma_pkt_write_not_read_o       out 1    1 = evict (write), 0 = refill (read)
//  dma_pkt_addr_o                 out AW   request address
//  dma_data_i / dma_data_v_i      in  WW/1 refill word from memory / valid
//  dma_data_ready_and_o           out 1    refill word accepted when v & ready
//  dma_data_o / dma_data_v_o      out WW/1 evict word to memory / valid
//  dma_data_yumi_i                in  1    evict word consumed
//  data_mem_v_o / data_mem_w_o    out 1/1  data mem access / write enable (engine has priority)
//  data_mem_addr_o                out DA   {index, way, word offset}
//  data_mem_data_o                out WW   refill write data
//  data_mem_data_i                in  WW   read data, valid one cycle after a read access
//  busy_o                         out 1    FSM not IDLE or refill pending
// BEHAVIOUR
//  Reset (async, reset_n_i=0): FSM->IDLE, refill_pending_r=0, counters=0, every output 0.
//   Reset mid-transfer abandons it; no done pulse.
//  FSM states: IDLE, REFILL_REQ, EVICT_REQ, EVICT_READ, EVICT_SEND.
//  IDLE: cmd==send_refill_addr & ~refill_pending_r -> latch addr/way, REFILL_REQ;
//   cmd==send_evict_addr -> latch addr/way, EVICT_REQ; nop/other -> stay.
//   Latched command is not re-accepted the cycle done pulses: return to IDLE after done.
//  REFILL_REQ: pkt_v_o=1, write_not_read=0; on pkt_yumi_i: done_o=1, refill_pending_r<=1, cnt<=0, IDLE.
//  EVICT_REQ: pkt_v_o=1, write_not_read=1; on pkt_yumi_i: done_o=1, evict_cnt<=0, EVICT_READ.
//  EVICT_READ: data_mem_v_o=1, w=0, addr={idx,way,evict_cnt} -> EVICT_SEND; word captured next cycle.
//  EVICT_SEND: data_v_o=1 with captured word; on yumi_i: if cnt==block-1 -> done_o=1, IDLE;
//   else cnt++, EVICT_READ. Throughput: one word per 2 cycles minimum.
//  Refill: ready_and_o = refill_pending_r & write_fill_data_in_progress_i & FSM==IDLE.
//   On v&ready: data_mem_v_o=w_o=1, addr={idx,way,refill_cnt}, data=dma_data_i, cnt++.
//   Last word (cnt==block-1) written: done_o=1 same cycle, refill_pending_r<=0.
//  Ordering: refill done never precedes evict-data done; refill words are back-pressured
//   (ready=0) while eviction in progress or MHU not in WRITE_FILL_DATA.
//  done_o sources are mutually exclusive by construction; at most one pulse per cycle.
//  Counters are lg_block_size_in_words bits, wrap to 0 after the last word.
//  Refill data arriving while refill_pending_r=0 is not accepted (ready=0).
//  pkt_addr_o = latched addr, low block_offset bits forced 0.
// TESTING
//  Clean refill, block=4: refill cmd, pkt_yumi at cycle 3 -> done at 3; wfip=1, 4 words ->
//   4 dmem writes word 0..3, done with last write, busy_o=0 next cycle.
//  Dirty evict: refill cmd, then evict cmd way=2 idx=5 -> write pkt; reads {5,2,0..3};
//   dma_data_o matches dmem contents in order; done on 4th yumi.
//  Refill words presented during eviction -> ready=0 until evict done and wfip=1; no lost words.
//  Backpressure: pkt_yumi delayed 10 cycles, data_yumi random 50% -> pkt/data held stable, no done early.
//  Async reset asserted mid-evict after word 1 -> all outputs 0 immediately; new refill cmd then runs clean.
//  Held refill cmd after done with refill_pending_r=1 -> no second packet issued.

Source files
------------

// File: rtl/bsg_cache_nb_dma_engine.sv
`default_nettype none
// ============================================================================
// Module  : bsg_cache_nb_dma_engine
// Brief   : DMA responder for the non-blocking cache miss handler. It issues
//           memory request packets, streams evicted words out of the data
//           mem, and writes refill words into it. Each completed phase is
//           reported with a one-cycle dma_done_o pulse.
// Revision: 1.0 - initial release
// ============================================================================
module bsg_cache_nb_dma_engine #(
  parameter int addr_width_p          = 32,
  parameter int word_width_p          = 32,
  parameter int block_size_in_words_p = 4,
  parameter int sets_p                = 8,
  parameter int ways_p                = 4,
  localparam int lg_sets_lp                = (sets_p == 1) ? 1 : $clog2(sets_p),
  localparam int lg_ways_lp                = (ways_p == 1) ? 1 : $clog2(ways_p),
  localparam int lg_block_size_in_words_lp = $clog2(block_size_in_words_p),
  localparam int dmem_addr_width_lp        = lg_sets_lp + lg_ways_lp + lg_block_size_in_words_lp
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,

  input  logic [2:0]                    dma_cmd_i,
  input  logic [addr_width_p-1:0]       dma_addr_i,
  input  logic [lg_ways_lp-1:0]         dma_way_i,
  input  logic                          write_fill_data_in_progress_i,
  output logic                          dma_done_o,

  output logic                          dma_pkt_v_o,
  input  logic                          dma_pkt_yumi_i,
  output logic                          dma_pkt_write_not_read_o,
  output logic [addr_width_p-1:0]       dma_pkt_addr_o,

  input  logic [word_width_p-1:0]       dma_data_i,
  input  logic                          dma_data_v_i,
  output logic                          dma_data_ready_and_o,

  output logic [word_width_p-1:0]       dma_data_o,
  output logic                          dma_data_v_o,
  input  logic                          dma_data_yumi_i,

  output logic                          data_mem_v_o,
  output logic                          data_mem_w_o,
  output logic [dmem_addr_width_lp-1:0] data_mem_addr_o,
  output logic [word_width_p-1:0]       data_mem_data_o,
  input  logic [word_width_p-1:0]       data_mem_data_i,

  output logic                          busy_o
);

  // Command encoding shared with the miss handler; other codes are ignored.
  localparam logic [2:0] e_dma_nop              = 3'd0;
  localparam logic [2:0] e_dma_send_refill_addr = 3'd1;
  localparam logic [2:0] e_dma_send_evict_addr  = 3'd2;

  localparam int byte_offset_lp  = $clog2(word_width_p / 8);
  localparam int block_offset_lp = byte_offset_lp + lg_block_size_in_words_lp;

  localparam logic [addr_width_p-1:0] block_mask_lp =
    {{(addr_width_p - block_offset_lp){1'b1}}, {block_offset_lp{1'b0}}};

  localparam logic [lg_block_size_in_words_lp-1:0] cnt_one_lp  = lg_block_size_in_words_lp'(1);
  localparam logic [lg_block_size_in_words_lp-1:0] cnt_last_lp =
    lg_block_size_in_words_lp'(block_size_in_words_p - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_REFILL_REQ = 3'd1,
    S_EVICT_REQ  = 3'd2,
    S_EVICT_READ = 3'd3,
    S_EVICT_SEND = 3'd4
  } state_e;

  state_e                                 state_q;
  logic                                   refill_pending_q;
  logic [addr_width_p-1:0]                addr_q;
  logic [lg_sets_lp-1:0]                  refill_idx_q;
  logic [lg_ways_lp-1:0]                  refill_way_q;
  logic [lg_sets_lp-1:0]                  evict_idx_q;
  logic [lg_ways_lp-1:0]                  evict_way_q;
  logic [lg_block_size_in_words_lp-1:0]   refill_cnt_q;
  logic [lg_block_size_in_words_lp-1:0]   evict_cnt_q;
  logic                                   evict_first_q;
  logic [word_width_p-1:0]                evict_data_q;

  logic [lg_sets_lp-1:0] cmd_idx;
  logic                  pkt_fire;
  logic                  evict_fire;
  logic                  evict_last;
  logic                  refill_ready;
  logic                  refill_write;
  logic                  refill_last;
  logic                  evict_rd;

  assign cmd_idx      = dma_addr_i[block_offset_lp +: lg_sets_lp];
  assign pkt_fire     = dma_pkt_v_o & dma_pkt_yumi_i;
  assign evict_fire   = (state_q == S_EVICT_SEND) & dma_data_yumi_i;
  assign evict_last   = (evict_cnt_q == cnt_last_lp);
  assign evict_rd     = (state_q == S_EVICT_READ);

  // Refill words only land while the engine is idle, so an eviction in
  // flight always drains before the same set/way is overwritten.
  assign refill_ready = refill_pending_q & write_fill_data_in_progress_i & (state_q == S_IDLE);
  assign refill_write = refill_ready & dma_data_v_i;
  assign refill_last  = (refill_cnt_q == cnt_last_lp);

  assign dma_pkt_v_o              = (state_q == S_REFILL_REQ) | (state_q == S_EVICT_REQ);
  assign dma_pkt_write_not_read_o = (state_q == S_EVICT_REQ);
  assign dma_pkt_addr_o           = addr_q;

  assign dma_data_ready_and_o = refill_ready;

  // The first send cycle forwards the read data directly; later cycles use
  // the captured copy since the data mem output is free to change.
  assign dma_data_v_o = (state_q == S_EVICT_SEND);
  assign dma_data_o   = dma_data_v_o
                      ? (evict_first_q ? data_mem_data_i : evict_data_q)
                      : '0;

  assign data_mem_v_o    = evict_rd | refill_write;
  assign data_mem_w_o    = refill_write;
  assign data_mem_addr_o = refill_write ? {refill_idx_q, refill_way_q, refill_cnt_q}
                         : evict_rd     ? {evict_idx_q, evict_way_q, evict_cnt_q}
                         : '0;
  assign data_mem_data_o = refill_write ? dma_data_i : '0;

  // Completion sources live in disjoint states, so at most one fires.
  assign dma_done_o = ((state_q == S_REFILL_REQ) & pkt_fire)
                    | ((state_q == S_EVICT_REQ)  & pkt_fire)
                    | (evict_fire & evict_last)
                    | (refill_write & refill_last);

  assign busy_o = (state_q != S_IDLE) | refill_pending_q;

  // Command FSM, transfer counters and evict word capture.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q          <= S_IDLE;
      refill_pending_q <= 1'b0;
      addr_q           <= '0;
      refill_idx_q     <= '0;
      refill_way_q     <= '0;
      evict_idx_q      <= '0;
      evict_way_q      <= '0;
      refill_cnt_q     <= '0;
      evict_cnt_q      <= '0;
      evict_first_q    <= 1'b0;
      evict_data_q     <= '0;
    end else begin
      if (refill_write) begin
        refill_cnt_q <= refill_cnt_q + cnt_one_lp;
        if (refill_last) begin
          refill_pending_q <= 1'b0;
        end
      end

      case (state_q)
        S_IDLE: begin
          if ((dma_cmd_i == e_dma_send_refill_addr) && !refill_pending_q) begin
            addr_q       <= dma_addr_i & block_mask_lp;
            refill_idx_q <= cmd_idx;
            refill_way_q <= dma_way_i;
            state_q      <= S_REFILL_REQ;
          end else if (dma_cmd_i == e_dma_send_evict_addr) begin
            addr_q      <= dma_addr_i & block_mask_lp;
            evict_idx_q <= cmd_idx;
            evict_way_q <= dma_way_i;
            state_q     <= S_EVICT_REQ;
          end else if (dma_cmd_i == e_dma_nop) begin
            state_q <= S_IDLE;
          end
        end

        S_REFILL_REQ: begin
          if (dma_pkt_yumi_i) begin
            refill_pending_q <= 1'b1;
            refill_cnt_q     <= '0;
            state_q          <= S_IDLE;
          end
        end

        S_EVICT_REQ: begin
          if (dma_pkt_yumi_i) begin
            evict_cnt_q <= '0;
            state_q     <= S_EVICT_READ;
          end
        end

        S_EVICT_READ: begin
          evict_first_q <= 1'b1;
          state_q       <= S_EVICT_SEND;
        end

        S_EVICT_SEND: begin
          evict_first_q <= 1'b0;
          if (evict_first_q) begin
            evict_data_q <= data_mem_data_i;
          end
          if (dma_data_yumi_i) begin
            evict_cnt_q <= evict_cnt_q + cnt_one_lp;
            state_q     <= evict_last ? S_IDLE : S_EVICT_READ;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bsg_cache_nb_dma_engine.sv
`default_nettype none
// ============================================================================
// Module  : tb_bsg_cache_nb_dma_engine
// Brief   : Self-checking bench for bsg_cache_nb_dma_engine: a cycle table
//           for the clean refill, then scoreboarded evict/refill sequences,
//           backpressure, async reset mid-evict and a held refill command.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bsg_cache_nb_dma_engine;

  localparam int AW = 32, WW = 32, BLK = 4, SETS = 8, WAYS = 4, DA = 7;
  localparam logic [2:0] NOP = 3'd0, REF = 3'd1, EVI = 3'd2;
  localparam logic H = 1'b1, L = 1'b0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_n_i;
  logic [2:0]     dma_cmd_i;
  logic [AW-1:0]  dma_addr_i;
  logic [1:0]     dma_way_i;
  logic           wfip;
  logic           dma_done_o;
  logic           dma_pkt_v_o, dma_pkt_yumi_i, dma_pkt_write_not_read_o;
  logic [AW-1:0]  dma_pkt_addr_o;
  logic [WW-1:0]  dma_data_i;
  logic           dma_data_v_i, dma_data_ready_and_o;
  logic [WW-1:0]  dma_data_o;
  logic           dma_data_v_o, dma_data_yumi_i;
  logic           data_mem_v_o, data_mem_w_o;
  logic [DA-1:0]  data_mem_addr_o;
  logic [WW-1:0]  data_mem_data_o;
  logic [WW-1:0]  rdata;
  logic           busy_o;

  bsg_cache_nb_dma_engine #(
    .addr_width_p(AW), .word_width_p(WW), .block_size_in_words_p(BLK),
    .sets_p(SETS), .ways_p(WAYS)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .dma_cmd_i(dma_cmd_i), .dma_addr_i(dma_addr_i), .dma_way_i(dma_way_i),
    .write_fill_data_in_progress_i(wfip), .dma_done_o(dma_done_o),
    .dma_pkt_v_o(dma_pkt_v_o), .dma_pkt_yumi_i(dma_pkt_yumi_i),
    .dma_pkt_write_not_read_o(dma_pkt_write_not_read_o), .dma_pkt_addr_o(dma_pkt_addr_o),
    .dma_data_i(dma_data_i), .dma_data_v_i(dma_data_v_i), .dma_data_ready_and_o(dma_data_ready_and_o),
    .dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o), .dma_data_yumi_i(dma_data_yumi_i),
    .data_mem_v_o(data_mem_v_o), .data_mem_w_o(data_mem_w_o), .data_mem_addr_o(data_mem_addr_o),
    .data_mem_data_o(data_mem_data_o), .data_mem_data_i(rdata), .busy_o(busy_o)
  );

  int checks = 0;
  int errors = 0;

  logic [DA+WW-1:0] wr_q [$];   // expected refill writes {addr, data}
  logic [WW-1:0]    ev_q [$];   // expected evict words in order
  logic [DA+WW-1:0] wr_e;

  // Data mem model: one-cycle read latency; idle cycles scramble the output.
  logic [WW-1:0] mem [0:127];
  always @(posedge clk) begin
    if (!reset_n_i) begin
      for (int i = 0; i < 128; i++) mem[i] <= $urandom;
      rdata <= $urandom;
    end else if (data_mem_v_o && data_mem_w_o) begin
      mem[data_mem_addr_o] <= data_mem_data_o;
      rdata <= $urandom;
    end else if (data_mem_v_o) begin
      rdata <= mem[data_mem_addr_o];
    end else begin
      rdata <= $urandom;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] outs();
    return {17'b0, dma_done_o, dma_pkt_v_o, dma_pkt_write_not_read_o, dma_pkt_addr_o,
            dma_data_ready_and_o, dma_data_o, dma_data_v_o, data_mem_v_o, data_mem_w_o,
            data_mem_addr_o, data_mem_data_o, busy_o};
  endfunction

  function automatic logic [DA-1:0] dmaddr(input int idx, input int way, input int k);
    return {3'(idx), 2'(way), 2'(k)};
  endfunction

  function automatic logic [AW-1:0] mkaddr(input logic [24:0] tag, input int idx);
    return {tag, 3'(idx), 4'h0};
  endfunction

  // Scoreboard for refill writes into the data mem.
  always @(negedge clk) begin
    if (reset_n_i && data_mem_v_o && data_mem_w_o) begin
      if (wr_q.size() == 0) begin
        chk("refill_wr_unexpected", 1, 0);
      end else begin
        wr_e = wr_q.pop_front();
        chk("refill_wr_addr", data_mem_addr_o, wr_e[DA+WW-1:WW]);
        chk("refill_wr_data", data_mem_data_o, wr_e[WW-1:0]);
      end
    end
  end

  // Waits for the packet, stalls yumi for 'delay' cycles, then consumes it.
  task automatic do_pkt(input logic exp_wnr, input logic [AW-1:0] exp_addr,
                        input int delay, input logic keep_cmd);
    int n = 0;
    dma_pkt_yumi_i = 1'b0;
    @(negedge clk);
    while (!dma_pkt_v_o && n < 50) begin
      @(posedge clk); #1; @(negedge clk); n++;
    end
    chk("pkt_v_seen", dma_pkt_v_o, 1);
    for (int i = 0; i < delay; i++) begin
      chk("pkt_hold_no_done", {dma_pkt_v_o, dma_done_o, dma_pkt_addr_o}, {H, L, exp_addr});
      @(posedge clk); #1; @(negedge clk);
    end
    @(posedge clk); #1;
    dma_pkt_yumi_i = 1'b1;
    @(negedge clk);
    chk("pkt_wnr", dma_pkt_write_not_read_o, exp_wnr);
    chk("pkt_addr", dma_pkt_addr_o, exp_addr);
    chk("pkt_done", dma_done_o, 1);
    @(posedge clk); #1;
    dma_pkt_yumi_i = 1'b0;
    if (!keep_cmd) dma_cmd_i = NOP;
  endtask

  // Drains the evict stream; refill words presented meanwhile must stall.
  task automatic run_evict(input int idx, input int way, input int pct, input int stop_after);
    int fires = 0, reads = 0, n = 0;
    logic done_seen = 1'b0, hold = 1'b0;
    logic [WW-1:0] held = '0;
    while (!done_seen && n < 300) begin
      dma_data_yumi_i = dma_data_v_o && ($urandom_range(99) < pct);
      @(negedge clk);
      if (data_mem_v_o && !data_mem_w_o) begin
        chk("evict_rd_addr", data_mem_addr_o, dmaddr(idx, way, reads));
        reads++;
      end
      if (dma_data_v_i) chk("refill_bp_during_evict", dma_data_ready_and_o, 0);
      if (hold && dma_data_v_o) chk("evict_data_stable", dma_data_o, held);
      hold = dma_data_v_o && !dma_data_yumi_i;
      held = dma_data_o;
      if (dma_data_v_o && dma_data_yumi_i) begin
        fires++;
        if (ev_q.size() == 0) chk("evict_word_unexpected", 1, 0);
        else chk("evict_word", dma_data_o, ev_q.pop_front());
      end
      if (dma_done_o) begin
        done_seen = 1'b1;
        chk("evict_done_on_last", fires, BLK);
      end
      if (stop_after != 0 && fires == stop_after) break;
      @(posedge clk); #1;
      n++;
    end
    if (stop_after == 0) begin
      chk("evict_done_seen", done_seen, 1);
      chk("evict_reads", reads, BLK);
      dma_data_yumi_i = 1'b0;
    end
  endtask

  // Presents refill words (optional gaps) until the last write reports done.
  task automatic run_refill(input logic [WW-1:0] w [BLK], input int gap);
    int k = 0, n = 0;
    logic seen = 1'b0;
    wfip = 1'b1;
    while (!seen && n < 100) begin
      dma_data_i   = w[k % BLK];
      dma_data_v_i = ($urandom_range(99) >= gap);
      @(negedge clk);
      if (dma_data_v_i && dma_data_ready_and_o) begin
        k++;
        if (dma_done_o) begin
          seen = 1'b1;
          chk("refill_done_on_last", k, BLK);
        end
      end else if (dma_done_o) begin
        seen = 1'b1;
        chk("refill_done_without_write", 0, 1);
      end
      @(posedge clk); #1;
      n++;
    end
    dma_data_v_i = 1'b0;
    wfip = 1'b0;
    chk("refill_done_seen", seen, 1);
    @(negedge clk);
    chk("busy_after_refill", busy_o, 0);
    chk("refill_no_lost_words", wr_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic push_words(input int idx, input int way, output logic [WW-1:0] w [BLK]);
    for (int k = 0; k < BLK; k++) begin
      w[k] = $urandom;
      wr_q.push_back({dmaddr(idx, way, k), w[k]});
    end
  endtask

  // Refill request, evict request + data, then refill data into the same set/way.
  task automatic evict_flow(input logic [24:0] tag_r, input logic [24:0] tag_e,
                            input int idx, input int way, input int pkt_delay,
                            input int pct, input int gap, input int stop_after);
    logic [WW-1:0] w [BLK];
    wfip = 1'b0; dma_data_v_i = 1'b0;
    dma_way_i  = 2'(way);
    dma_addr_i = mkaddr(tag_r, idx) | 32'h9;
    dma_cmd_i  = REF;
    do_pkt(1'b0, mkaddr(tag_r, idx), pkt_delay, 1'b0);
    dma_addr_i = mkaddr(tag_e, idx) | 32'h5;
    dma_cmd_i  = EVI;
    for (int k = 0; k < BLK; k++) ev_q.push_back(mem[dmaddr(idx, way, k)]);
    do_pkt(1'b1, mkaddr(tag_e, idx), pkt_delay, 1'b0);
    push_words(idx, way, w);
    dma_data_i = w[0]; dma_data_v_i = 1'b1; wfip = 1'b1;
    run_evict(idx, way, pct, stop_after);
    if (stop_after == 0) run_refill(w, gap);
  endtask

  typedef struct {
    logic [2:0]    cmd;
    logic          pkt_yumi, wfip, dv;
    logic [WW-1:0] d;
    logic          e_pkt_v, e_done, e_ready, e_mem_w, e_busy;
  } vec_t;
  vec_t vt [11];

  initial begin
    int nw;
    logic [WW-1:0] w [BLK];
    reset_n_i = 1'b0; dma_cmd_i = NOP; dma_addr_i = '0; dma_way_i = '0; wfip = 1'b0;
    dma_pkt_yumi_i = 1'b0; dma_data_i = '0; dma_data_v_i = 1'b0; dma_data_yumi_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", outs(), 0);
    reset_n_i = 1'b1;
    @(posedge clk); #1;

    // Clean refill, one row per cycle: pkt consumed at cycle 3, words 0..3.
    vt[0]  = '{REF, L, L, L, 32'h0,         L, L, L, L, L};
    vt[1]  = '{REF, L, L, L, 32'h0,         H, L, L, L, H};
    vt[2]  = '{REF, L, L, L, 32'h0,         H, L, L, L, H};
    vt[3]  = '{REF, H, L, L, 32'h0,         H, H, L, L, H};
    vt[4]  = '{NOP, L, L, H, 32'hA0A0_0001, L, L, L, L, H};
    vt[5]  = '{NOP, L, H, H, 32'hA0A0_0001, L, L, H, H, H};
    vt[6]  = '{NOP, L, H, H, 32'hB1B1_0002, L, L, H, H, H};
    vt[7]  = '{NOP, L, H, L, 32'hDEAD_BEEF, L, L, H, L, H};
    vt[8]  = '{NOP, L, H, H, 32'hC2C2_0003, L, L, H, H, H};
    vt[9]  = '{NOP, L, H, H, 32'hD3D3_0004, L, H, H, H, H};
    vt[10] = '{NOP, L, L, L, 32'h0,         L, L, L, L, L};
    dma_addr_i = 32'h0000_123B;
    dma_way_i  = 2'd1;
    nw = 0;
    for (int r = 0; r < 11; r++) begin
      dma_cmd_i      = vt[r].cmd;
      dma_pkt_yumi_i = vt[r].pkt_yumi;
      wfip           = vt[r].wfip;
      dma_data_v_i   = vt[r].dv;
      dma_data_i     = vt[r].d;
      if (vt[r].dv && vt[r].e_ready) begin
        wr_q.push_back({dmaddr(3, 1, nw), vt[r].d});
        nw++;
      end
      @(negedge clk);
      chk($sformatf("table_row%0d", r),
          {dma_pkt_v_o, dma_done_o, dma_data_ready_and_o, data_mem_v_o, data_mem_w_o, busy_o, dma_pkt_write_not_read_o},
          {vt[r].e_pkt_v, vt[r].e_done, vt[r].e_ready, vt[r].e_mem_w, vt[r].e_mem_w, vt[r].e_busy, L});
      if (vt[r].e_pkt_v) chk($sformatf("table_pkt_addr%0d", r), dma_pkt_addr_o, 32'h0000_1230);
      @(posedge clk); #1;
    end
    dma_pkt_yumi_i = 1'b0; dma_data_v_i = 1'b0; wfip = 1'b0;

    // Dirty evict idx 5 way 2, no backpressure.
    evict_flow(25'h00_0ABC, 25'h00_0DEF, 5, 2, 0, 100, 0, 0);

    // Backpressure: packets stalled 10 cycles, random evict yumi and refill gaps.
    evict_flow(25'h01_2345, 25'h1F_0F0F, 6, 3, 10, 50, 40, 0);

    // Async reset after the first evict word: everything drops at once.
    evict_flow(25'h00_0777, 25'h00_0888, 2, 0, 0, 100, 0, 1);
    #2;
    reset_n_i = 1'b0;
    #1;
    chk("async_reset_outputs", outs(), 0);
    ev_q.delete(); wr_q.delete();
    dma_cmd_i = NOP; dma_data_v_i = 1'b0; wfip = 1'b0; dma_data_yumi_i = 1'b0; dma_pkt_yumi_i = 1'b0;
    @(negedge clk);
    reset_n_i = 1'b1;
    @(posedge clk); #1;
    dma_addr_i = mkaddr(25'h00_0999, 4); dma_way_i = 2'd3; dma_cmd_i = REF;
    do_pkt(1'b0, mkaddr(25'h00_0999, 4), 0, 1'b0);
    push_words(4, 3, w);
    run_refill(w, 0);

    // Refill command held after its done while refill still pending.
    dma_addr_i = mkaddr(25'h00_0555, 1); dma_way_i = 2'd0; dma_cmd_i = REF;
    do_pkt(1'b0, mkaddr(25'h00_0555, 1), 0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("held_refill_no_second_pkt", {dma_pkt_v_o, dma_done_o, busy_o}, {L, L, H});
      @(posedge clk); #1;
    end
    dma_cmd_i = NOP;
    push_words(1, 0, w);
    run_refill(w, 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running, expected to have finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
